alarm_timekeeper: RTL

Parametrised 24-hour BCD timekeeper with a settable alarm, a ringing FSM, snooze and auto-timeout. Sits between the board clock and the 7-segment mux and song player. It replaces the ad-hoc seconds/minutes counters and the toggle-based alarm trigger. Its `ringing` output drives the song player's play input and the LED flash logic.

---
 rtl/alarm_timekeeper.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_timekeeper.sv
// rtl/alarm_timekeeper.sv - 24-hour BCD timekeeper with settable alarm, ringing FSM, snooze and auto-timeout
// Optional feature macro: ALARM_SNOOZE_EN (snooze input, SNOOZED state and snooze counter)
module alarm_timekeeper #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter logic [15:0] ALARM_RST      = 16'h0700
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  set_mode,
    input  logic        inc_h,
    input  logic        inc_m,
    input  logic        alarm_en,
    input  logic        snooze,
    input  logic        dismiss,
    output logic [23:0] time_bcd,
    output logic [15:0] alarm_bcd,
    output logic        sec_pulse,
    output logic        ringing,
    output logic        snoozed
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam int unsigned RING_W = $clog2(RING_TIMEOUT_S + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
    logic [SNZ_W-1:0] snz_cnt;
`else
    typedef enum logic {IDLE, RINGING} state_t;
    logic unused_snooze;
    assign unused_snooze = snooze;
    assign snoozed = 1'b0;
`endif

    state_t            state;
    logic [PRE_W-1:0]  pre_cnt;
    logic [PRE_W-1:0]  pre_next;
    logic [RING_W-1:0] ring_cnt;
    logic [23:0]       time_next;
    logic [15:0]       alarm_next;
    logic              in_set_time;
    logic              in_set_alarm;
    logic              match;

    assign in_set_time  = (set_mode == 2'b01);
    assign in_set_alarm = (set_mode == 2'b10);

    // BCD 00..59 increment with wrap; only legal digits are ever produced
    function automatic logic [7:0] bcd_inc_mod60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD 00..23 increment with wrap
    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Next time: manual edit in set-time mode, otherwise ripple-carry on each second
    always_comb begin
        time_next = time_bcd;
        if (in_set_time) begin
            time_next[7:0] = 8'h00;
            if (inc_m)
                time_next[15:8] = bcd_inc_mod60(time_bcd[15:8]);
            if (inc_h)
                time_next[23:16] = bcd_inc_hour(time_bcd[23:16]);
        end else if (sec_pulse) begin
            time_next[7:0] = bcd_inc_mod60(time_bcd[7:0]);
            if (time_bcd[7:0] == 8'h59) begin
                time_next[15:8] = bcd_inc_mod60(time_bcd[15:8]);
                if (time_bcd[15:8] == 8'h59)
                    time_next[23:16] = bcd_inc_hour(time_bcd[23:16]);
            end
        end
    end

    // Next alarm: only editable in set-alarm mode, minutes do not carry into hours
    always_comb begin
        alarm_next = alarm_bcd;
        if (in_set_alarm) begin
            if (inc_m)
                alarm_next[7:0] = bcd_inc_mod60(alarm_bcd[7:0]);
            if (inc_h)
                alarm_next[15:8] = bcd_inc_hour(alarm_bcd[15:8]);
        end
    end

    // Match against the next-state time so ringing rises with the HH:MM:00 update
    assign match = alarm_en && !in_set_time && sec_pulse && (time_next == {alarm_bcd, 8'h00});

    assign pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);

    // Prescaler and second strobe; held at zero while the time is being set
    always_ff @(posedge clk) begin
        if (reset || in_set_time) begin
            pre_cnt   <= '0;
            sec_pulse <= 1'b0;
        end else begin
            pre_cnt   <= pre_next;
            sec_pulse <= (pre_next == PRE_LAST);
        end
    end

    // Time and alarm registers
    always_ff @(posedge clk) begin
        if (reset) begin
            time_bcd  <= 24'h000000;
            alarm_bcd <= ALARM_RST;
        end else begin
            time_bcd  <= time_next;
            alarm_bcd <= alarm_next;
        end
    end

    // Alarm FSM with registered ringing/snoozed flags
    always_ff @(posedge clk) begin
        if (reset || in_set_time) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
            snoozed  <= 1'b0;
            snz_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (!alarm_en || dismiss) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze) begin
                        state   <= SNOOZED;
                        ringing <= 1'b0;
                        snoozed <= 1'b1;
                        snz_cnt <= SNZ_LOAD;
                    end
`endif
                    else if (sec_pulse) begin
                        if (ring_cnt == RING_LAST) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + RING_W'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZED: begin
                    if (!alarm_en || dismiss) begin
                        state   <= IDLE;
                        snoozed <= 1'b0;
                    end else if (sec_pulse) begin
                        if (snz_cnt == SNZ_W'(1)) begin
                            state    <= RINGING;
                            ringing  <= 1'b1;
                            snoozed  <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - SNZ_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    snoozed <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule
